// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// DUTY_W matches the PWM generator's speed input width.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    localparam int DUTY_W    = 3;
    localparam int DIV_STEPS = 3;

endpackage

// File: rtl/pwm_capture_if.sv
// Control and result bundle of the PWM capture block.
// The master drives enable and the PWM input; the slave returns the measurement.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    import pwm_pkg::*;

    logic              ena;
    logic              pwm_in;
    logic [CNT_W-1:0]  period_o;
    logic [CNT_W-1:0]  high_o;
    logic [DUTY_W-1:0] duty_o;
    logic              valid_o;
    logic              stuck_o;

    modport master (
        output ena, pwm_in,
        input  period_o, high_o, duty_o, valid_o, stuck_o
    );

    modport slave (
        input  ena, pwm_in,
        output period_o, high_o, duty_o, valid_o, stuck_o
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for the asynchronous PWM pin, followed by one
// edge-detect flop producing single-cycle rise/fall strobes.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an incoming PWM waveform and
// derives a 3-bit duty code with a short restoring divider.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);

    localparam int STEP_W = $clog2(DIV_STEPS);

    logic w_level, w_rise, w_fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_per_cnt, r_hi_cnt;
    logic                r_hi_run;
    logic [CNT_W-1:0]    r_per_s, r_hi_s;
    logic [CNT_W:0]      r_rem, w_rem_sh, w_rem_next;
    logic [DUTY_W-1:0]   r_quo, w_quo_next;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W-1:0]    r_period, r_high;
    logic [DUTY_W-1:0]   r_duty;
    logic                r_valid, r_stuck;
    logic                w_sat, w_snap, w_done, w_ge;

    // A rise in the same cycle as saturation takes priority.
    assign w_sat = (r_per_cnt == '1) && !w_rise;

    assign w_rem_sh   = r_rem << 1;
    assign w_ge       = (w_rem_sh >= {1'b0, r_per_s});
    assign w_rem_next = w_ge ? (w_rem_sh - {1'b0, r_per_s}) : w_rem_sh;
    assign w_quo_next = (r_quo << 1) | DUTY_W'(w_ge);

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_next = MEASURE;
            end
            MEASURE: begin
                if (w_rise) begin
                    w_state_next = DIVIDE;
                    w_snap       = 1'b1;
                end else if (w_sat) begin
                    w_state_next = IDLE;
                end
            end
            DIVIDE: begin
                if (w_sat) begin
                    w_state_next = IDLE;
                end else if (r_step == STEP_W'(DIV_STEPS - 1)) begin
                    w_state_next = MEASURE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (!bus.ena) begin
            w_state_next = IDLE;
            w_snap       = 1'b0;
            w_done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_run  <= 1'b0;
            r_stuck   <= 1'b0;
        end else begin
            if (!bus.ena || w_sat) begin
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_hi_run  <= 1'b0;
            end else if (w_rise) begin
                r_per_cnt <= CNT_W'(1);
                r_hi_cnt  <= CNT_W'(1);
                r_hi_run  <= 1'b1;
            end else if (r_state != IDLE) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
                if (r_hi_run && w_level) r_hi_cnt <= r_hi_cnt + CNT_W'(1);
                if (w_fall)              r_hi_run <= 1'b0;
            end

            if (!bus.ena || w_rise) r_stuck <= 1'b0;
            else if (w_sat)         r_stuck <= 1'b1;
        end
    end

    // Divider: one quotient bit per DIVIDE cycle, MSB first; results land on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_s  <= '0;
            r_hi_s   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_step   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_duty   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_snap) begin
                r_per_s <= r_per_cnt;
                r_hi_s  <= r_hi_cnt;
                r_rem   <= {1'b0, r_hi_cnt};
                r_quo   <= '0;
                r_step  <= '0;
            end else if (r_state == DIVIDE) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_step <= r_step + STEP_W'(1);
            end
            if (w_done) begin
                r_period <= r_per_s;
                r_high   <= r_hi_s;
                r_duty   <= w_quo_next;
            end
        end
    end

    assign bus.period_o = r_period;
    assign bus.high_o   = r_high;
    assign bus.duty_o   = r_duty;
    assign bus.valid_o  = r_valid;
    assign bus.stuck_o  = r_stuck;

endmodule
